// File: rtl/fifo_tx_pkg.sv
// -----------------------------------------------------------------------------
// fifo_tx_pkg
// Shared definitions for the SpaceWire transmit packet FIFO.
//   EOP_CODE / EEP_CODE : N-Char end-of-packet / error-end-of-packet tokens
//   is_eop_eep()        : true when a 9-bit token is either end marker
//   clog2()             : ceiling log2 for elaboration-time sizing
// -----------------------------------------------------------------------------
package fifo_tx_pkg;

    localparam logic [8:0] EOP_CODE = 9'h100;
    localparam logic [8:0] EEP_CODE = 9'h101;

    // An end marker is a control token whose payload bits [7:1] are all zero.
    function automatic logic is_eop_eep(input logic [8:0] token);
        return (token == EOP_CODE) || (token == EEP_CODE);
    endfunction

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_tx_ram.sv
// -----------------------------------------------------------------------------
// fifo_tx_ram
// DEPTH x DWIDTH register array, one synchronous write port and one
// combinational read port. Contents are deliberately not reset.
// Ports:
//   clock  : write clock
//   we     : write enable
//   waddr  : write address
//   wdata  : write data
//   raddr  : read address
//   rdata  : read data (combinational from raddr)
// -----------------------------------------------------------------------------
module fifo_tx_ram #(
    parameter int DWIDTH = 9,
    parameter int AWIDTH = 6
) (
    input  logic              clock,
    input  logic              we,
    input  logic [AWIDTH-1:0] waddr,
    input  logic [DWIDTH-1:0] wdata,
    input  logic [AWIDTH-1:0] raddr,
    output logic [DWIDTH-1:0] rdata
);

    localparam int DEPTH = 2 ** AWIDTH;

    logic [DWIDTH-1:0] mem_r [DEPTH];

    // Storage write port.
    always_ff @(posedge clock) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/fifo_tx_pkt.sv
// -----------------------------------------------------------------------------
// fifo_tx_pkt
// Transmit FIFO for SpaceWire N-Char tokens between the host write side and
// the TX encoder read side. Holds up to 2**AWIDTH tokens, tracks how many
// complete packets (EOP/EEP markers) are buffered, and offers edge or level
// handshakes on both strobes.
// Ports:
//   clock, reset      : clock; asynchronous active-low reset
//   flush             : synchronous clear of contents (wins over wr/rd)
//   wr_en, data_in    : write strobe and token
//   rd_en             : read acknowledge from the encoder
//   data_out          : registered head token
//   write_tx          : data_out valid / request to encoder
//   f_full, f_empty   : exact occupancy flags
//   almost_full/empty : threshold flags (>= AF_LEVEL, <= AE_LEVEL)
//   counter           : occupancy 0..DEPTH
//   pkt_count         : number of end markers held
// -----------------------------------------------------------------------------
module fifo_tx_pkt
    import fifo_tx_pkg::*;
#(
    parameter int DWIDTH    = 9,
    parameter int AWIDTH    = 6,
    parameter bit EDGE_MODE = 1'b1,
    parameter int AF_LEVEL  = 2 ** AWIDTH - 4,
    parameter int AE_LEVEL  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [DWIDTH-1:0] data_in,
    input  logic              rd_en,
    output logic [DWIDTH-1:0] data_out,
    output logic              write_tx,
    output logic              f_full,
    output logic              f_empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [AWIDTH:0]   counter,
    output logic [AWIDTH:0]   pkt_count
);

    localparam int              DEPTH   = 2 ** AWIDTH;
    localparam logic [AWIDTH:0] DEPTH_C = (AWIDTH + 1)'(DEPTH);
    localparam logic [AWIDTH:0] AF_C    = (AWIDTH + 1)'(AF_LEVEL);
    localparam logic [AWIDTH:0] AE_C    = (AWIDTH + 1)'(AE_LEVEL);
    localparam logic [AWIDTH:0] CNT_ONE = (AWIDTH + 1)'(1);
    localparam logic [AWIDTH-1:0] PTR_ONE = AWIDTH'(1);

    // Registered state
    logic [AWIDTH-1:0] wr_ptr_r, rd_ptr_r;
    logic [AWIDTH:0]   counter_r, pkt_count_r;
    logic              wr_block_r, rd_block_r;
    logic              f_full_r, f_empty_r, almost_full_r, almost_empty_r;
    logic              write_tx_r;
    logic [DWIDTH-1:0] data_out_r;

    // Next-state and decode
    logic              wa_raw_s, ra_raw_s, wa_s, ra_s;
    logic              wr_block_next_s, rd_block_next_s;
    logic [AWIDTH-1:0] wr_ptr_next_s, rd_ptr_next_s;
    logic [AWIDTH:0]   counter_next_s, pkt_count_next_s;
    logic              f_empty_next_s, write_tx_next_s, bypass_s;
    logic              pkt_inc_s, pkt_dec_s;
    logic [DWIDTH-1:0] data_out_next_s, ram_rdata_s;
    logic [8:0]        wr_tok_s, head_tok_s;

    // Packet markers live in the low 9 bits; narrower tokens carry none.
    generate
        if (DWIDTH >= 9) begin : g_tok
            assign wr_tok_s   = data_in[8:0];
            assign head_tok_s = data_out_r[8:0];
        end else begin : g_no_tok
            assign wr_tok_s   = 9'd0;
            assign head_tok_s = 9'd0;
        end
    endgenerate

    fifo_tx_ram #(
        .DWIDTH (DWIDTH),
        .AWIDTH (AWIDTH)
    ) u_ram (
        .clock (clock),
        .we    (wa_s),
        .waddr (wr_ptr_r),
        .wdata (data_in),
        .raddr (rd_ptr_next_s),
        .rdata (ram_rdata_s)
    );

    // Handshake, pointer, occupancy and head-token next-state logic.
    always_comb begin
        wa_raw_s = wr_en & ~f_full_r   & (~EDGE_MODE | ~wr_block_r);
        ra_raw_s = rd_en & write_tx_r  & (~EDGE_MODE | ~rd_block_r);
        // Flush swallows any strobe it coincides with; the strobe still
        // counts as consumed for the block flags.
        wa_s     = wa_raw_s & ~flush;
        ra_s     = ra_raw_s & ~flush;

        if (wa_raw_s) begin
            wr_block_next_s = 1'b1;
        end else if (!wr_en) begin
            wr_block_next_s = 1'b0;
        end else begin
            wr_block_next_s = wr_block_r;
        end

        if (ra_raw_s) begin
            rd_block_next_s = 1'b1;
        end else if (!rd_en) begin
            rd_block_next_s = 1'b0;
        end else begin
            rd_block_next_s = rd_block_r;
        end

        pkt_inc_s = wa_s & is_eop_eep(wr_tok_s);
        pkt_dec_s = ra_s & is_eop_eep(head_tok_s);

        if (flush) begin
            wr_ptr_next_s    = {AWIDTH{1'b0}};
            rd_ptr_next_s    = {AWIDTH{1'b0}};
            counter_next_s   = {(AWIDTH + 1){1'b0}};
            pkt_count_next_s = {(AWIDTH + 1){1'b0}};
        end else begin
            wr_ptr_next_s = wa_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
            rd_ptr_next_s = ra_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
            case ({wa_s, ra_s})
                2'b10:   counter_next_s = counter_r + CNT_ONE;
                2'b01:   counter_next_s = counter_r - CNT_ONE;
                default: counter_next_s = counter_r;
            endcase
            case ({pkt_inc_s, pkt_dec_s})
                2'b10:   pkt_count_next_s = pkt_count_r + CNT_ONE;
                2'b01:   pkt_count_next_s = pkt_count_r - CNT_ONE;
                default: pkt_count_next_s = pkt_count_r;
            endcase
        end

        f_empty_next_s  = (counter_next_s == {(AWIDTH + 1){1'b0}});
        write_tx_next_s = ~f_empty_next_s & ~(EDGE_MODE & rd_block_next_s);

        // The token being written lands exactly where the next head is read
        // from (empty FIFO, or a single entry being read out this cycle);
        // the array still holds stale data there, so forward data_in.
        bypass_s = wa_s & (wr_ptr_r == rd_ptr_next_s);

        if (f_empty_next_s) begin
            data_out_next_s = data_out_r;
        end else if (bypass_s) begin
            data_out_next_s = data_in;
        end else begin
            data_out_next_s = ram_rdata_s;
        end
    end

    // State registers; flags are taken from the next-state counter so they
    // change in the same cycle as counter itself.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_r       <= {AWIDTH{1'b0}};
            rd_ptr_r       <= {AWIDTH{1'b0}};
            counter_r      <= {(AWIDTH + 1){1'b0}};
            pkt_count_r    <= {(AWIDTH + 1){1'b0}};
            wr_block_r     <= 1'b0;
            rd_block_r     <= 1'b0;
            f_full_r       <= 1'b0;
            f_empty_r      <= 1'b1;
            almost_full_r  <= 1'b0;
            almost_empty_r <= 1'b1;
            write_tx_r     <= 1'b0;
            data_out_r     <= {DWIDTH{1'b0}};
        end else begin
            wr_ptr_r       <= wr_ptr_next_s;
            rd_ptr_r       <= rd_ptr_next_s;
            counter_r      <= counter_next_s;
            pkt_count_r    <= pkt_count_next_s;
            wr_block_r     <= wr_block_next_s;
            rd_block_r     <= rd_block_next_s;
            f_full_r       <= (counter_next_s == DEPTH_C);
            f_empty_r      <= f_empty_next_s;
            almost_full_r  <= (counter_next_s >= AF_C);
            almost_empty_r <= (counter_next_s <= AE_C);
            write_tx_r     <= write_tx_next_s;
            data_out_r     <= data_out_next_s;
        end
    end

    assign data_out     = data_out_r;
    assign write_tx     = write_tx_r;
    assign f_full       = f_full_r;
    assign f_empty      = f_empty_r;
    assign almost_full  = almost_full_r;
    assign almost_empty = almost_empty_r;
    assign counter      = counter_r;
    assign pkt_count    = pkt_count_r;

endmodule

// File: doc/fifo_tx_pkt.md
Name: fifo_tx_pkt

Overview:
Parametrised successor to the SpaceWire transmit FIFO. It buffers N-Char tokens (bit 8 = control flag; 0x100 = EOP, 0x101 = EEP) between the host write side and the TX encoder read side. Compared with the current TX FIFO it adds:
- true full at 2**AWIDTH entries, with flags that are exact in the same cycle;
- a selectable edge-handshake or level-handshake mode;
- almost-full and almost-empty thresholds;
- a count of complete packets held;
- a synchronous flush.

Parameters:
- DWIDTH, 9: token width; bit 8 is the control flag when DWIDTH≥9.
- AWIDTH, 6: address width; DEPTH = 2**AWIDTH.
- EDGE_MODE, 1: 1 = one entry per wr_en/rd_en assertion (pulse-stretched handshake); 0 = one entry per cycle while the strobe is high.
- AF_LEVEL, 2**AWIDTH-4: almost_full asserts when count ≥ AF_LEVEL.
- AE_LEVEL, 4: almost_empty asserts when count ≤ AE_LEVEL.

Ports:
- clock, in, 1: single clock domain.
- reset, in, 1: asynchronous, active-low.
- flush, in, 1: synchronous clear of FIFO contents.
- wr_en, in, 1: write strobe.
- data_in, in, DWIDTH: token to write.
- rd_en, in, 1: read strobe / acknowledge from the TX encoder.
- data_out, out, DWIDTH: registered head token.
- write_tx, out, 1: data_out valid, request to the encoder.
- f_full, out, 1: count == DEPTH.
- f_empty, out, 1: count == 0.
- almost_full, out, 1: count ≥ AF_LEVEL.
- almost_empty, out, 1: count ≤ AE_LEVEL.
- counter, out, AWIDTH+1: occupancy, 0..DEPTH.
- pkt_count, out, AWIDTH+1: number of EOP/EEP tokens held.

Behaviour:
- Reset: pointers 0; counter 0; pkt_count 0; f_empty 1; f_full 0; almost_empty 1; almost_full 0; data_out 0; write_tx 0; block flags 0. Memory contents are not reset.
- Write accept (wa): wr_en & !f_full & (!EDGE_MODE | !wr_block). On wa: mem[wr_ptr] <= data_in, wr_ptr+1. In EDGE_MODE, wr_block sets on wa and clears in the first cycle wr_en is low.
- Read accept (ra): rd_en & write_tx & (!EDGE_MODE | !rd_block). On ra: rd_ptr+1. rd_block follows the same rule as wr_block.
- Pointer wrap: pointers are AWIDTH bits wide and wrap modulo DEPTH naturally. Full and empty are distinguished only by counter.
- counter: wa & !ra → +1; ra & !wa → −1; both or neither → hold.
- Flags: f_full, f_empty, almost_full and almost_empty are registered from the next-state counter, so they are exact in the same cycle counter changes. There is no one-cycle lag.
- Simultaneous wa/ra requests:
  - When full: the read is accepted and the write is rejected, since wa is gated by f_full. The write side retries.
  - When empty: the write is accepted and the read is rejected, since write_tx = 0.
- pkt_count:
  - +1 on wa of an end marker (data_in[8] = 1 and data_in[7:1] = 0).
  - −1 on ra of an end marker at the head.
  - Both in the same cycle → hold.
- data_out / write_tx:
  - data_out <= mem[rd_ptr_next] every cycle.
  - When writing into an empty FIFO, data_in is bypassed to data_out.
  - Latency from an accepted write to an empty FIFO until write_tx = 1 is 1 cycle.
  - write_tx = !f_empty_next & !(EDGE_MODE & rd_block_next).
  - After ra, the next head appears 1 cycle later, or write_tx drops if the FIFO becomes empty.
  - When empty, data_out holds its last value.
- flush: takes priority over wa and ra in the same cycle. It sets counter, pkt_count and both pointers to 0, f_empty 1 and write_tx 0. Block flags are not cleared, so a held strobe is not re-accepted.
- Reset mid-operation: all state returns to reset values immediately (asynchronous); any partial handshake is discarded.
- Width rules:
  - Arithmetic is unsigned with modulo-2**AWIDTH pointers.
  - counter never exceeds DEPTH and never goes below 0.
  - The design must be illegal-state free for AWIDTH 2..10.

Decomposition:
- Package fifo_tx_pkg: localparams EOP_CODE = 9'h100 and EEP_CODE = 9'h101, is_eop_eep function, clog2 function.
- One sub-module, fifo_tx_ram: DEPTH×DWIDTH register array with synchronous write port and read-address port, no reset.
- fifo_tx_pkt holds the pointers, counters, flags, handshake and bypass.

Test Plan (DWIDTH = 9, AWIDTH = 6, EDGE_MODE = 1 unless noted):
1. Reset, then a single pulse write of 0x0A5 → counter = 1, f_empty = 0, write_tx = 1 one cycle later, data_out = 0x0A5. Then a single rd_en pulse → counter = 0, f_empty = 1, write_tx = 0.
2. Write 64 distinct tokens 0x000..0x03F with pulses → f_full = 1 and counter = 64 on the 64th accept; almost_full = 1 from counter = 60. A 65th write is ignored. Reading all 64 returns them in order with wrap-around through pointer 63→0.
3. With the FIFO full, assert wr_en and rd_en together → read accepted, write rejected, counter = 63, f_full = 0 in the same cycle. Hold rd_en high for 5 cycles in edge mode → only 1 read is accepted.
4. EDGE_MODE = 0: hold wr_en for 10 cycles with an incrementing data_in → counter = 10. Hold rd_en and wr_en together for 8 cycles → counter stays 10 and output order is preserved.
5. Write 0x041, 0x100 (EOP), 0x042, 0x101 (EEP) → pkt_count = 2. Read 2 tokens → pkt_count = 1.
6. Write 20 tokens, then assert flush together with wr_en → counter = 0, pkt_count = 0, f_empty = 1, write_tx = 0. Assert reset low mid-burst → all outputs return to reset values asynchronously.
